// File: rtl/axi_lite_master.sv
// AXI4-Lite single-outstanding master: a command/response front end drives one
// AXI4-Lite read or write at a time. The wait counter flags slow slaves but never aborts.
module axi_lite_master #(
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic                                M_AXI_ACLK,
    input  logic                                M_AXI_ARESETN,
    // command side
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]       cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]       cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]     cmd_wstrb,
    // response side
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]       rsp_rdata,
    output logic [1:0]                          rsp_resp,
    output logic                                busy,
    output logic                                timeout,
    // AXI4-Lite write address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]       M_AXI_AWADDR,
    output logic [2:0]                          M_AXI_AWPROT,
    output logic                                M_AXI_AWVALID,
    input  logic                                M_AXI_AWREADY,
    // AXI4-Lite write data
    output logic [C_M_AXI_DATA_WIDTH-1:0]       M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]     M_AXI_WSTRB,
    output logic                                M_AXI_WVALID,
    input  logic                                M_AXI_WREADY,
    // AXI4-Lite write response
    input  logic [1:0]                          M_AXI_BRESP,
    input  logic                                M_AXI_BVALID,
    output logic                                M_AXI_BREADY,
    // AXI4-Lite read address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]       M_AXI_ARADDR,
    output logic [2:0]                          M_AXI_ARPROT,
    output logic                                M_AXI_ARVALID,
    input  logic                                M_AXI_ARREADY,
    // AXI4-Lite read data
    input  logic [C_M_AXI_DATA_WIDTH-1:0]       M_AXI_RDATA,
    input  logic [1:0]                          M_AXI_RRESP,
    input  logic                                M_AXI_RVALID,
    output logic                                M_AXI_RREADY
);

    localparam int unsigned DATA_W = C_M_AXI_DATA_WIDTH;
    localparam int unsigned ADDR_W = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned STRB_W = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = 16;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                write_q, write_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                aw_fin, w_fin, in_wait;

    // Next-state, handshake flags, capture registers and wait counter
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        write_d     = write_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;
        aw_fin      = 1'b0;
        w_fin       = 1'b0;
        in_wait     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    write_d   = cmd_write;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    if (cmd_write) begin
                        state_d   = ST_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WR: begin
                in_wait   = 1'b1;
                // a channel is finished once its VALID has already dropped or handshakes now
                aw_fin    = ~awvalid_q | M_AXI_AWREADY;
                w_fin     = ~wvalid_q | M_AXI_WREADY;
                awvalid_d = awvalid_q & ~M_AXI_AWREADY;
                wvalid_d  = wvalid_q & ~M_AXI_WREADY;
                if (aw_fin && w_fin) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            ST_WR_RESP: begin
                in_wait = 1'b1;
                if (M_AXI_BVALID) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = M_AXI_BRESP;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_RD_ADDR: begin
                in_wait = 1'b1;
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                in_wait = 1'b1;
                if (M_AXI_RVALID) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_resp_d  = M_AXI_RRESP;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // saturating wait counter; the flag is sticky until the next accept
        if (in_wait) begin
            if (cnt_q < CNT_LIMIT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_d == CNT_LIMIT) begin
                timeout_d = 1'b1;
            end
        end

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            write_q     <= write_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign busy          = busy_q;
    assign timeout       = timeout_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: the bench plays the AXI slave by hand, cycle by cycle.
module tb_axi_lite_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy, timeout;
    logic [11:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;

    int checks = 0;
    int errors = 0;

    axi_lite_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(12),
        .TIMEOUT_CYCLES    (8)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESETN(rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .busy         (busy),
        .timeout      (timeout),
        .M_AXI_AWADDR (awaddr),
        .M_AXI_AWPROT (awprot),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA  (wdata),
        .M_AXI_WSTRB  (wstrb),
        .M_AXI_WVALID (wvalid),
        .M_AXI_WREADY (wready),
        .M_AXI_BRESP  (bresp),
        .M_AXI_BVALID (bvalid),
        .M_AXI_BREADY (bready),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARPROT (arprot),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA  (rdata),
        .M_AXI_RRESP  (rresp),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge, then settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;

        // reset state
        step(); step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_valids", 32'({awvalid, wvalid, arvalid, rsp_valid}), 32'd0);
        chk("rst_readies", 32'({bready, rready}), 32'd0);
        chk("rst_rsp", 32'({rsp_rdata, rsp_resp}), 32'd0);
        #4 rst_n = 1'b1;
        step();
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("prot", 32'({awprot, arprot}), 32'd0);

        // write, always-ready slave, OKAY response
        awready = 1'b1; wready = 1'b1;
        issue(1'b1, 12'h008, 32'hA5A5_0001, 4'hF);
        chk("w1_awvalid", 32'(awvalid), 32'd1);
        chk("w1_wvalid", 32'(wvalid), 32'd1);
        chk("w1_awaddr", 32'(awaddr), 32'h008);
        chk("w1_wdata", wdata, 32'hA5A5_0001);
        chk("w1_wstrb", 32'(wstrb), 32'hF);
        chk("w1_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("w1_busy", 32'(busy), 32'd1);
        step();
        awready = 1'b0; wready = 1'b0;
        chk("w1_valids_drop", 32'({awvalid, wvalid}), 32'd0);
        chk("w1_bready", 32'(bready), 32'd1);
        bvalid = 1'b1; bresp = 2'b00;
        step();
        bvalid = 1'b0;
        chk("w1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("w1_rsp_resp", 32'(rsp_resp), 32'd0);
        chk("w1_rsp_rdata", rsp_rdata, 32'd0);
        chk("w1_bready_off", 32'(bready), 32'd0);
        release_rsp();

        // read, ARREADY held off for 3 cycles
        issue(1'b0, 12'h004, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            chk("r1_arvalid_hold", 32'(arvalid), 32'd1);
            chk("r1_araddr_hold", 32'(araddr), 32'h004);
            chk("r1_rready_off", 32'(rready), 32'd0);
            if (i < 2) step();
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("r1_arvalid_drop", 32'(arvalid), 32'd0);
        chk("r1_rready", 32'(rready), 32'd1);
        rvalid = 1'b1; rdata = 32'h2024_0101; rresp = 2'b00;
        step();
        rvalid = 1'b0; rdata = '0;
        chk("r1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("r1_rsp_rdata", rsp_rdata, 32'h2024_0101);
        chk("r1_rsp_resp", 32'(rsp_resp), 32'd0);
        chk("r1_rready_off2", 32'(rready), 32'd0);
        chk("r1_no_timeout", 32'(timeout), 32'd0);
        release_rsp();

        // write, W accepted two cycles before AW
        wready = 1'b1;
        issue(1'b1, 12'h010, 32'h1234_5678, 4'h3);
        step();
        wready = 1'b0;
        chk("w2_wvalid_drop", 32'(wvalid), 32'd0);
        chk("w2_awvalid_hold", 32'(awvalid), 32'd1);
        chk("w2_bready_wait", 32'(bready), 32'd0);
        step();
        chk("w2_awvalid_hold2", 32'(awvalid), 32'd1);
        chk("w2_awaddr_stable", 32'(awaddr), 32'h010);
        awready = 1'b1;
        step();
        awready = 1'b0;
        chk("w2_awvalid_drop", 32'(awvalid), 32'd0);
        chk("w2_bready", 32'(bready), 32'd1);
        bvalid = 1'b1; bresp = 2'b00;
        step();
        bvalid = 1'b0;
        chk("w2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("w2_bready_off", 32'(bready), 32'd0);
        release_rsp();

        // write, AW accepted two cycles before W, DECERR passes through
        awready = 1'b1;
        issue(1'b1, 12'h020, 32'hCAFE_0002, 4'hC);
        step();
        awready = 1'b0;
        chk("w3_awvalid_drop", 32'(awvalid), 32'd0);
        chk("w3_wvalid_hold", 32'(wvalid), 32'd1);
        chk("w3_bready_wait", 32'(bready), 32'd0);
        step();
        chk("w3_wvalid_hold2", 32'(wvalid), 32'd1);
        chk("w3_wdata_stable", wdata, 32'hCAFE_0002);
        chk("w3_wstrb_stable", 32'(wstrb), 32'hC);
        wready = 1'b1;
        step();
        wready = 1'b0;
        chk("w3_wvalid_drop", 32'(wvalid), 32'd0);
        chk("w3_bready", 32'(bready), 32'd1);
        bvalid = 1'b1; bresp = 2'b11;
        step();
        bvalid = 1'b0; bresp = 2'b00;
        chk("w3_rsp_resp", 32'(rsp_resp), 32'd3);
        chk("w3_rsp_rdata", rsp_rdata, 32'd0);
        release_rsp();

        // read with SLVERR, response held back for 4 cycles, new command pending
        arready = 1'b1;
        issue(1'b0, 12'h0FC, 32'h0, 4'h0);
        step();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
        step();
        rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h3FF;
        for (int i = 0; i < 4; i++) begin
            chk("r2_rsp_valid_hold", 32'(rsp_valid), 32'd1);
            chk("r2_rsp_resp_hold", 32'(rsp_resp), 32'd2);
            chk("r2_rsp_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);
            chk("r2_cmd_ready_off", 32'(cmd_ready), 32'd0);
            chk("r2_no_aw", 32'(awvalid), 32'd0);
            step();
        end
        cmd_valid = 1'b0;
        release_rsp();

        // slave never answers AR: timeout after 8 wait cycles, transaction kept alive
        issue(1'b0, 12'h100, 32'h0, 4'h0);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("t1_no_timeout_yet", 32'(timeout), 32'd0);
        end
        step();
        chk("t1_timeout", 32'(timeout), 32'd1);
        chk("t1_arvalid_kept", 32'(arvalid), 32'd1);
        step(); step();
        chk("t1_timeout_sticky", 32'(timeout), 32'd1);
        chk("t1_arvalid_kept2", 32'(arvalid), 32'd1);
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0000_00A1; rresp = 2'b00;
        step();
        rvalid = 1'b0; rdata = '0;
        chk("t1_rsp_rdata", rsp_rdata, 32'h0000_00A1);
        chk("t1_timeout_in_done", 32'(timeout), 32'd1);
        release_rsp();

        // next accept clears the flag; then stall again and reset mid-transaction
        issue(1'b0, 12'h104, 32'h0, 4'h0);
        chk("t2_timeout_cleared", 32'(timeout), 32'd0);
        for (int i = 0; i < 9; i++) step();
        chk("t2_timeout", 32'(timeout), 32'd1);
        chk("t2_arvalid", 32'(arvalid), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("t2_rst_arvalid", 32'(arvalid), 32'd0);
        chk("t2_rst_timeout", 32'(timeout), 32'd0);
        chk("t2_rst_busy", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        step();
        chk("t2_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t2_rready", 32'(rready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
